uart_tx_arbiter: RTL and testbench

Round-robin, packet-granular arbiter that shares one UART transmitter among PORTS AXI-stream byte sources. A grant is held from the first beat of a packet until its tlast beat, so packets from different sources never interleave on the serial line. The output is a single registered AXI-stream that connects directly to the transmitter's s_axis interface. It sits between the per-client TX byte streams and the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmitter stream.
// Define UART_ARB_ID_HDR_EN to prefix every packet with its source-ID byte.
module uart_tx_arbiter #(
    parameter  int PORTS      = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int IDW        = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        grant_valid,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef UART_ARB_ID_HDR_EN
    localparam logic [1:0] ST_HDR  = 2'd1;
`endif
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic                  grant_valid_q, grant_valid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;

    logic [DATA_WIDTH-1:0] s_data [PORTS];
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid;
    logic                  g_last;
    logic                  can_load;
    logic                  in_data;
    logic                  xfer;
    logic                  found;
    logic [IDW-1:0]        pick;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_split
        assign s_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign g_data   = s_data[grant_id_q];
    assign g_valid  = s_axis_tvalid[grant_id_q];
    assign g_last   = s_axis_tlast[grant_id_q];
    assign can_load = !tvalid_q || m_axis_tready;
    assign in_data  = (state_q == ST_DATA);
    assign xfer     = in_data && g_valid && can_load;

    always_comb begin
        s_axis_tready = '0;
        if (in_data) begin
            s_axis_tready[grant_id_q] = can_load;
        end
    end

    // Scan starts just after the previous owner so every port gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= PORTS; i++) begin
            int            idx;
            logic [IDW-1:0] cand;
            idx  = (int'(last_grant_q) + i) % PORTS;
            cand = IDW'(idx);
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;

        if (can_load) begin
            if (xfer) begin
                tvalid_d = 1'b1;
                tdata_d  = g_data;
                tlast_d  = g_last;
            end else begin
                tvalid_d = 1'b0;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_id_d    = pick;
                    grant_valid_d = 1'b1;
`ifdef UART_ARB_ID_HDR_EN
                    state_d       = ST_HDR;
`else
                    state_d       = ST_DATA;
`endif
                end
            end
`ifdef UART_ARB_ID_HDR_EN
            ST_HDR: begin
                if (can_load) begin
                    tvalid_d = 1'b1;
                    tdata_d  = DATA_WIDTH'(grant_id_q);
                    tlast_d  = 1'b0;
                    state_d  = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                if (xfer && g_last) begin
                    last_grant_d  = grant_id_q;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= IDW'(PORTS - 1);
            grant_valid_q <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            tvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            tvalid_q      <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign grant_valid   = grant_valid_q;
    assign grant_id      = grant_id_q;
    assign busy          = grant_valid_q | tvalid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle model plus directed cases.
// Honours UART_ARB_ID_HDR_EN when the design is built with it.
module tb_uart_tx_arbiter;

    localparam int P  = 4;
    localparam int DW = 8;
`ifdef UART_ARB_ID_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [P*DW-1:0] s_tdata;
    logic [P-1:0]  s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic          gv, busy;
    logic [1:0]    gid;

    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .grant_valid(gv), .grant_id(gid), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW:0] srcq [P][$];
    bit          stall [P];
    bit          rand_stall = 0;
    bit          sink_rand = 0;
    bit          sinkpat [$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [P-1:0] xfer_seen = '0;
    logic [DW:0] outlog [$];
    int          outcyc [$];
    int          glog [$];
    bit          gv_prev = 0;

    // model state
    int          owner = -1, last_g = P - 1;
    bit          hdr_pend = 0, mo_valid = 0, mo_last = 0;
    logic [DW-1:0] mo_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int lg, input logic [P-1:0] v);
        for (int i = 1; i <= P; i++) begin
            if (v[(lg + i) % P]) return (lg + i) % P;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic         cl, xf;
        logic [P-1:0] er;
        int           o;
        cyc++;
        if (!rst_n) begin
            chk("rst_m_tvalid", 32'(m_tvalid), 0);
            chk("rst_m_tdata", 32'(m_tdata), 0);
            chk("rst_m_tlast", 32'(m_tlast), 0);
            chk("rst_s_tready", 32'(s_tready), 0);
            chk("rst_grant_valid", 32'(gv), 0);
            chk("rst_grant_id", 32'(gid), 0);
            chk("rst_busy", 32'(busy), 0);
            owner = -1; last_g = P - 1; hdr_pend = 0;
            mo_valid = 0; mo_last = 0; mo_data = '0;
            xfer_seen = '0; gv_prev = 0;
        end else begin
            cl = !mo_valid || m_tready;
            er = '0;
            if (owner >= 0 && !hdr_pend && cl) er = P'(1) << owner;
            chk("m_tvalid", 32'(m_tvalid), 32'(mo_valid));
            if (mo_valid) begin
                chk("m_tdata", 32'(m_tdata), 32'(mo_data));
                chk("m_tlast", 32'(m_tlast), 32'(mo_last));
            end
            chk("grant_valid", 32'(gv), 32'(owner >= 0));
            if (owner >= 0) chk("grant_id", 32'(gid), 32'(owner));
            chk("busy", 32'(busy), 32'(owner >= 0 || mo_valid));
            chk("s_tready", 32'(s_tready), 32'(er));
            if (gv && !gv_prev) glog.push_back(int'(gid));
            gv_prev = gv;
            if (m_tvalid && m_tready) begin
                outlog.push_back({m_tlast, m_tdata});
                outcyc.push_back(cyc);
            end
            xfer_seen = s_tvalid & s_tready;
            o  = owner;
            xf = (o >= 0) && !hdr_pend && s_tvalid[o] && cl;
            if (cl) begin
                if (xf) begin
                    mo_valid = 1; mo_data = s_tdata[o*DW +: DW]; mo_last = s_tlast[o];
                end else if (o >= 0 && hdr_pend) begin
                    mo_valid = 1; mo_data = DW'(o); mo_last = 0;
                end else begin
                    mo_valid = 0;
                end
            end
            if (o < 0) begin
                if (|s_tvalid) begin
                    owner = rr_pick(last_g, s_tvalid);
                    hdr_pend = HDR;
                end
            end else if (hdr_pend) begin
                if (cl) hdr_pend = 0;
            end else if (xf && s_tlast[o]) begin
                last_g = o;
                owner = -1;
            end
        end
    end

    task automatic drive();
        for (int p = 0; p < P; p++) begin
            logic [DW:0] b;
            if (srcq[p].size() > 0) begin
                b = srcq[p][0];
                s_tvalid[p] = !stall[p];
                s_tdata[p*DW +: DW] = b[DW-1:0];
                s_tlast[p] = b[DW];
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[p*DW +: DW] = '0;
                s_tlast[p] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) begin
            if (xfer_seen[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
            if (rand_stall) stall[p] = ($urandom_range(9) < 2);
        end
        if (sinkpat.size() > 0) m_tready = sinkpat.pop_front();
        else if (sink_rand) m_tready = ($urandom_range(9) < 7);
        else m_tready = 1'b1;
        drive();
    endtask

    task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++)
            srcq[p].push_back({(i == len - 1), DW'(base + DW'(i))});
    endtask

    function automatic bit pending();
        for (int p = 0; p < P; p++) if (srcq[p].size() > 0) return 1;
        return 0;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((pending() || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < budget), 1);
        tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int p = 0; p < P; p++) srcq[p].delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        outlog.delete(); outcyc.delete(); glog.delete();
    endtask

    initial begin
        logic [DW:0] exp_q [$];
        int n0, npk, nbt, step;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // port 2 three bytes
        clear_logs();
        add_pkt(2, 3, 8'h41);
        wait_idle("t1_done", 50);
        exp_q.delete();
        if (HDR) exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h42});
        exp_q.push_back({1'b1, 8'h43});
        chk("t1_len", 32'(outlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < outlog.size(); i++)
            chk("t1_beat", 32'(outlog[i]), 32'(exp_q[i]));
        chk("t1_grants", 32'(glog.size()), 1);
        if (glog.size() > 0) chk("t1_gid", 32'(glog[0]), 2);
        for (int i = 1; i < outcyc.size(); i++)
            chk("t1_b2b", 32'(outcyc[i] - outcyc[i-1]), 1);

        // ports 0,1,3 two rounds after reset
        do_reset();
        clear_logs();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 2, DW'(8'h00 + r * 8));
            add_pkt(1, 2, DW'(8'h10 + r * 8));
            add_pkt(3, 2, DW'(8'h30 + r * 8));
        end
        drive();
        wait_idle("t2_done", 100);
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            int order [3] = '{0, 1, 3};
            for (int k = 0; k < 3; k++) begin
                if (HDR) exp_q.push_back({1'b0, DW'(order[k])});
                exp_q.push_back({1'b0, DW'(order[k] * 16 + r * 8)});
                exp_q.push_back({1'b1, DW'(order[k] * 16 + r * 8 + 1)});
            end
        end
        chk("t2_len", 32'(outlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < outlog.size(); i++)
            chk("t2_beat", 32'(outlog[i]), 32'(exp_q[i]));
        chk("t2_ngrant", 32'(glog.size()), 6);
        for (int i = 0; i < glog.size() && i < 6; i++)
            chk("t2_order", 32'(glog[i]), 32'((i % 3 == 2) ? 3 : i % 3));

        // sink stalls during port 1 packet
        clear_logs();
        add_pkt(1, 3, 8'h10);
        sinkpat = '{1, 1, 0, 0, 1, 0, 1};
        wait_idle("t3_done", 60);
        exp_q.delete();
        if (HDR) exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h12});
        chk("t3_len", 32'(outlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < outlog.size(); i++)
            chk("t3_beat", 32'(outlog[i]), 32'(exp_q[i]));

        // port 0 stalls mid-packet while port 3 waits
        clear_logs();
        add_pkt(0, 3, 8'h50);
        step = 0;
        while (srcq[0].size() > 2 && step < 20) begin
            tick();
            step++;
        end
        chk("t4_first_beat", 32'(srcq[0].size()), 2);
        stall[0] = 1;
        add_pkt(3, 2, 8'h60);
        drive();
        repeat (20) begin
            tick();
            chk("t4_hold_gid", 32'(gid), 0);
            chk("t4_hold_gv", 32'(gv), 1);
            chk("t4_p3_rdy", 32'(s_tready[3]), 0);
        end
        stall[0] = 0;
        drive();
        wait_idle("t4_done", 60);
        chk("t4_ngrant", 32'(glog.size()), 2);
        if (glog.size() == 2) begin
            chk("t4_g0", 32'(glog[0]), 0);
            chk("t4_g1", 32'(glog[1]), 3);
        end

        // async reset mid-packet
        add_pkt(2, 5, 8'h70);
        step = 0;
        while (!(m_tvalid && gv) && step < 20) begin
            tick();
            step++;
        end
        chk("t5_midpkt", 32'(m_tvalid && gv), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_tvalid", 32'(m_tvalid), 0);
        chk("t5_async_gv", 32'(gv), 0);
        chk("t5_async_busy", 32'(busy), 0);
        for (int p = 0; p < P; p++) srcq[p].delete();
        add_pkt(0, 1, 8'h80);
        add_pkt(2, 1, 8'h82);
        drive();
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_logs();
        wait_idle("t5_done", 40);
        chk("t5_ngrant", 32'(glog.size()), 2);
        if (glog.size() == 2) begin
            chk("t5_g0", 32'(glog[0]), 0);
            chk("t5_g1", 32'(glog[1]), 2);
        end

        // single-beat packets alternating between ports 0 and 1
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            add_pkt(0, 1, 8'hAA);
            add_pkt(1, 1, 8'hAA);
        end
        drive();
        wait_idle("t6_done", 100);
        chk("t6_ngrant", 32'(glog.size()), 12);
        if (glog.size() > 0) chk("t6_first", 32'(glog[0]), 0);
        for (int i = 1; i < glog.size(); i++)
            chk("t6_alt", 32'(glog[i]), 32'(1 - glog[i-1]));
        begin
            int prev = -1;
            for (int i = 0; i < outlog.size(); i++) begin
                if (outlog[i] == {1'b1, 8'hAA}) begin
                    if (prev >= 0) chk("t6_spacing", 32'(outcyc[i] - prev), HDR ? 3 : 2);
                    prev = outcyc[i];
                end
            end
        end

        // randomized traffic, random sink and source stalls
        n0 = outlog.size();
        npk = 0; nbt = 0;
        sink_rand = 1; rand_stall = 1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) begin
                int p = $urandom_range(P - 1);
                int l = $urandom_range(5, 1);
                add_pkt(p, l, DW'($urandom));
                npk++;
                nbt += l;
            end
            tick();
        end
        wait_idle("t7_drain", 4000);
        sink_rand = 0; rand_stall = 0;
        for (int p = 0; p < P; p++) stall[p] = 0;
        wait_idle("t7_settle", 50);
        chk("t7_beats", 32'(outlog.size() - n0), 32'(nbt + (HDR ? npk : 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
